// File: rtl/chien_search.sv
// ----------------------------------------------------------------------------
// chien_search
//
// Chien search over GF(2^M). Finds the roots of the error-locator polynomial
// sigma(x) by evaluating it at alpha^0, alpha^1, ... alpha^(N-1), one element
// per clock. Register r_j holds sigma_j * alpha^(i*j) and is advanced every
// step by the constant multiplier alpha^j, so sigma(alpha^i) is the XOR of
// all r_j. A zero sum at step i is an error at bit position (N-i) mod N.
//
// Parameters:
//   M          field width, N = 2^M - 1
//   T          correction capability (max degree of sigma)
//   PRIM_POLY  primitive polynomial including the x^M term
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   start      one-cycle request, sampled only while idle
//   sigma      packed coefficients, sigma[j*M +: M] = sigma_j
//   degree     number of expected errors
//   busy       high from the cycle after an accepted start until done
//   err_valid  one-cycle pulse per root found
//   err_pos    error bit position, valid with err_valid (0 otherwise)
//   done       one-cycle completion pulse
//   err_count  roots found; held until the next start
//   fail       uncorrectable indication; held until the next start
//
// Build option:
//   CHIEN_EARLY_EXIT_EN  when defined, the search stops as soon as the
//                        number of roots found equals degree.
// ----------------------------------------------------------------------------
module chien_search #(
    parameter int          M         = 4,
    parameter int          T         = 3,
    parameter int unsigned PRIM_POLY = 'h13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(T+1)*M-1:0]     sigma,
    input  logic [$clog2(T+2)-1:0] degree,
    output logic                   busy,
    output logic                   err_valid,
    output logic [M-1:0]           err_pos,
    output logic                   done,
    output logic [$clog2(T+2)-1:0] err_count,
    output logic                   fail
);

    localparam int           CW       = $clog2(T+2);
    localparam logic [M-1:0] N_VAL    = {M{1'b1}};
    localparam logic [M-1:0] POLY_LOW = M'(PRIM_POLY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Multiply by alpha (= x) once, reducing by the primitive polynomial.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] v);
        logic [M-1:0] res;
        res = {v[M-2:0], 1'b0};
        if (v[M-1]) begin
            res = res ^ POLY_LOW;
        end
        return res;
    endfunction

    // Multiply by alpha^k for a constant k; folds into XOR gates.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] v, input int k);
        logic [M-1:0] res;
        res = v;
        for (int n = 0; n < k; n++) begin
            res = mul_alpha(res);
        end
        return res;
    endfunction

    state_t         state_q, state_d;
    logic [M-1:0]   r_q      [0:T];
    logic [M-1:0]   r_step   [0:T];
    logic [M-1:0]   r_load   [0:T];
    logic [M-1:0]   i_q, i_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  deg_q, deg_d;
    logic           fail_q, fail_d;
    logic           load_en, clear_en, step_en;
    logic [M-1:0]   sum;

    // Per-coefficient load value and constant-multiplier next value.
    // Coefficients above the requested degree are forced to zero.
    generate
        for (genvar gi = 0; gi <= T; gi++) begin : g_coef
            assign r_step[gi] = mul_alpha_pow(r_q[gi], gi);
            assign r_load[gi] = (CW'(gi) <= degree) ? sigma[gi*M +: M] : '0;
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int j = 0; j <= T; j++) begin
            sum = sum ^ r_q[j];
        end
    end

    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        cnt_d     = cnt_q;
        deg_d     = deg_q;
        fail_d    = fail_q;
        load_en   = 1'b0;
        clear_en  = 1'b0;
        step_en   = 1'b0;
        err_valid = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    i_d     = '0;
                    cnt_d   = '0;
                    deg_d   = degree;
                    state_d = SEARCH;
                    if ((degree > CW'(T)) || (sigma[M-1:0] == '0)) begin
                        // Invalid request: a single abort cycle in SEARCH
                        // (no evaluation) keeps done at the same latency
                        // as the shortest real search.
                        fail_d   = 1'b1;
                        clear_en = 1'b1;
                    end else begin
                        fail_d  = 1'b0;
                        load_en = 1'b1;
                    end
                end
            end

            SEARCH: begin
                if (fail_q) begin
                    state_d = FINISH;
                end else begin
                    step_en = 1'b1;
                    i_d     = i_q + 1'b1;
                    if (sum == '0) begin
                        err_valid = 1'b1;
                        if (cnt_q != CW'(T)) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    if (i_q == N_VAL - 1'b1) begin
                        state_d = FINISH;
                    end
`ifdef CHIEN_EARLY_EXIT_EN
                    if (cnt_d == deg_q) begin
                        state_d = FINISH;
                    end
`endif
                end
            end

            FINISH: begin
                done    = 1'b1;
                fail_d  = fail_q | (cnt_q != deg_q);
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            cnt_q   <= '0;
            deg_q   <= '0;
            fail_q  <= 1'b0;
            for (int j = 0; j <= T; j++) begin
                r_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            cnt_q   <= cnt_d;
            deg_q   <= deg_d;
            fail_q  <= fail_d;
            for (int j = 0; j <= T; j++) begin
                if (load_en) begin
                    r_q[j] <= r_load[j];
                end else if (clear_en) begin
                    r_q[j] <= '0;
                end else if (step_en) begin
                    r_q[j] <= r_step[j];
                end
            end
        end
    end

    // (N - i) mod N: with N all ones, N - i is ~i, and i = 0 maps to 0.
    assign err_pos   = err_valid ? ((i_q == '0) ? '0 : ~i_q) : '0;
    assign busy      = (state_q != IDLE);
    assign err_count = cnt_q;
    // Show the final verdict already in the done cycle.
    assign fail      = fail_q | ((state_q == FINISH) && (cnt_q != deg_q));

endmodule

// File: tb/tb_chien_search.sv
module tb_chien_search;

    localparam int M  = 4;
    localparam int T  = 3;
    localparam int CW = 3;

`ifdef CHIEN_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [15:0]     sigma;
    logic [CW-1:0]   degree;
    logic            busy;
    logic            err_valid;
    logic [M-1:0]    err_pos;
    logic            done;
    logic [CW-1:0]   err_count;
    logic            fail;

    int tests_run    = 0;
    int tests_failed = 0;

    chien_search #(.M(M), .T(T), .PRIM_POLY('h13)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sigma     (sigma),
        .degree    (degree),
        .busy      (busy),
        .err_valid (err_valid),
        .err_pos   (err_pos),
        .done      (done),
        .err_count (err_count),
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One search: start is driven in cycle 0; outputs are sampled on the
    // falling edge of each following cycle. p0/c0 and p1/c1 are the expected
    // first and second root (position, cycle).
    task automatic run(input string name, input logic [15:0] sig, input int deg,
                       input int exp_n, input int p0, input int c0,
                       input int p1, input int c1, input int exp_done,
                       input int exp_cnt, input int exp_fail, input int restart_at);
        int nv;
        int done_cyc;
        nv       = 0;
        done_cyc = -1;
        @(negedge clk);
        start  = 1'b1;
        sigma  = sig;
        degree = CW'(deg);
        @(posedge clk);
        #1;
        start  = 1'b0;
        sigma  = 16'hFFFF;
        degree = 3'd7;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) check({name, " busy"}, busy, 1);
            if (err_valid) begin
                nv++;
                if (nv == 1) begin
                    check({name, " root0 cycle"}, cyc, c0);
                    check({name, " root0 pos"}, err_pos, p0);
                end else if (nv == 2) begin
                    check({name, " root1 cycle"}, cyc, c1);
                    check({name, " root1 pos"}, err_pos, p1);
                end
            end
            if (done) begin
                done_cyc = cyc;
                check({name, " done cycle"}, cyc, exp_done);
                check({name, " err_count at done"}, err_count, exp_cnt);
                break;
            end
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                sigma  = 16'h0011;
                degree = 3'd1;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check({name, " timeout waiting for done"}, 0, 1);
        check({name, " root count"}, nv, exp_n);
        @(negedge clk);
        check({name, " busy after done"}, busy, 0);
        check({name, " err_count hold"}, err_count, exp_cnt);
        check({name, " fail hold"}, fail, exp_fail);
        $display("[TB] %s: roots=%0d done_cycle=%0d err_count=%0d fail=%0d",
                 name, nv, done_cyc, err_count, fail);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        sigma  = '0;
        degree = '0;
        #1;
        check("reset busy", busy, 0);
        check("reset err_valid", err_valid, 0);
        check("reset done", done, 0);
        check("reset err_count", err_count, 0);
        check("reset fail", fail, 0);
        check("reset err_pos", err_pos, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // sigma = 1 + F x + A x^2: errors at positions 7 and 2
        run("two_err", 16'h0AF1, 2, 2, 7, 9, 2, 14, EE ? 15 : 16, 2, 0, 0);
        // sigma = 1 + x: error at position 0 (first step)
        run("pos0", 16'h0011, 1, 1, 0, 1, 0, 0, EE ? 2 : 16, 1, 0, 0);
        // sigma = 1 + alpha x: error at position 1 (last step)
        run("pos1", 16'h0021, 1, 1, 1, 15, 0, 0, 16, 1, 0, 0);
        // sigma = (1 + x)^2: repeated root counts once
        run("repeated", 16'h0101, 2, 1, 0, 1, 0, 0, 16, 1, 1, 0);
        // invalid requests
        run("deg_gt_t", 16'h0AF1, 4, 0, 0, 0, 0, 0, 2, 0, 1, 0);
        run("sigma0_zero", 16'h0AF0, 2, 0, 0, 0, 0, 0, 2, 0, 1, 0);
        // degree 0: higher coefficients ignored, no roots
        run("deg0", 16'h0AF5, 0, 0, 0, 0, 0, 0, EE ? 2 : 16, 0, 0, 0);
        // start pulsed while busy is ignored
        run("restart_ignored", 16'h0AF1, 2, 2, 7, 9, 2, 14, EE ? 15 : 16, 2, 0, 5);

        // reset in the middle of a search
        @(negedge clk);
        start  = 1'b1;
        sigma  = 16'h0AF1;
        degree = 3'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("abort busy before rst", busy, 1);
        rst = 1'b1;
        #1;
        check("abort busy", busy, 0);
        check("abort err_valid", err_valid, 0);
        check("abort done", done, 0);
        check("abort err_count", err_count, 0);
        check("abort fail", fail, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) check("abort spurious done", done, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) check("abort activity after release", 1, 0);
        end
        $display("[TB] abort: reset mid-search handled");
        run("after_abort", 16'h0AF1, 2, 2, 7, 9, 2, 14, EE ? 15 : 16, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
